// File: rtl/dvs_ravens_pkg.sv
// Shared field layout and types for the DVS <-> RAVENS event link.
package dvs_ravens_pkg;

    localparam int X_BITS                 = 9;
    localparam int Y_BITS                 = 9;
    localparam int TIMESTAMP_US_BITS      = 45;
    localparam int EVENT_BITS             = 64;
    localparam int RAVENS_PKT_BITS        = 32;
    localparam int RAVENS_WORDS_PER_EVENT = 2;

    // Bit positions inside the 64-bit event word {x, y, pol, ts}
    localparam int X_MSB      = 63;
    localparam int Y_MSB      = 54;
    localparam int POL_BIT    = 45;
    localparam int TS_HI_BITS = 13;

    // Sensor array is 346 x 260; addresses at or above these are invalid
    localparam logic [X_BITS-1:0] X_LIMIT = 9'd346;
    localparam logic [Y_BITS-1:0] Y_LIMIT = 9'd260;

    typedef struct packed {
        logic [X_BITS-1:0]            x;
        logic [Y_BITS-1:0]            y;
        logic                         pol;
        logic [TIMESTAMP_US_BITS-1:0] ts;
    } dvs_event_t;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } ravens_depkt_state_t;

endpackage

// File: rtl/dvs_event_checker.sv
// Combinational range / timestamp-order check for one DVS event.
module dvs_event_checker
    import dvs_ravens_pkg::*;
(
    input  logic [EVENT_BITS-1:0]        ev_in,
    input  logic [TIMESTAMP_US_BITS-1:0] last_ts,
    output logic                         addr_ok,
    output logic                         ts_order_ok
);

    dvs_event_t ev;

    // Unpack the flat word and compare fields unsigned
    always_comb begin
        ev          = ev_in;
        addr_ok     = (ev.x < X_LIMIT) && (ev.y < Y_LIMIT);
        ts_order_ok = (ev.ts >= last_ts);
    end

endmodule

// File: rtl/ravens_event_depacketizer.sv
// Rebuilds 64-bit DVS events from pairs of 32-bit RAVENS packets,
// dropping out-of-range addresses and flagging timestamp regressions.
module ravens_event_depacketizer
    import dvs_ravens_pkg::*;
#(
    parameter int DROP_CNT_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RAVENS_PKT_BITS-1:0] pkt_in,
    input  logic                       pkt_in_valid,
    output logic                       pkt_in_ready,
    input  logic                       resync,
    output logic [EVENT_BITS-1:0]      event_out,
    output logic                       event_out_valid,
    input  logic                       event_out_ready,
    output logic                       err_addr,
    output logic                       err_ts_order,
    output logic [DROP_CNT_BITS-1:0]   drop_count
);

    ravens_depkt_state_t          state_q, state_d;
    logic [RAVENS_PKT_BITS-1:0]   hi_q, hi_d;
    logic [EVENT_BITS-1:0]        event_q, event_d;
    logic                         valid_q, valid_d;
    logic                         err_addr_q, err_addr_d;
    logic                         err_ts_q, err_ts_d;
    logic [DROP_CNT_BITS-1:0]     drop_q, drop_d;
    logic [TIMESTAMP_US_BITS-1:0] last_ts_q, last_ts_d;

    logic                         accept;
    logic [EVENT_BITS-1:0]        assembled;
    logic                         addr_ok;
    logic                         ts_order_ok;

    assign assembled = {hi_q, pkt_in};

    dvs_event_checker u_checker (
        .ev_in       (assembled),
        .last_ts     (last_ts_q),
        .addr_ok     (addr_ok),
        .ts_order_ok (ts_order_ok)
    );

    // Handshake: the low word may only land when the output slot is free
    // or is being drained this same cycle.
    always_comb begin
        pkt_in_ready = !rst && !resync &&
                       (state_q == WAIT_HI || !valid_q || event_out_ready);
        accept       = pkt_in_valid && pkt_in_ready;
    end

    // Assembly FSM, validation and output slot management
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        event_d    = event_q;
        valid_d    = valid_q && !event_out_ready;
        err_addr_d = 1'b0;
        err_ts_d   = 1'b0;
        drop_d     = drop_q;
        last_ts_d  = last_ts_q;

        if (resync) begin
            // Drop any half-built event; the held output is left alone
            state_d = WAIT_HI;
            hi_d    = '0;
        end else if (accept) begin
            case (state_q)
                WAIT_HI: begin
                    hi_d    = pkt_in;
                    state_d = WAIT_LO;
                end
                WAIT_LO: begin
                    state_d = WAIT_HI;
                    if (!addr_ok) begin
                        err_addr_d = 1'b1;
                        if (drop_q != {DROP_CNT_BITS{1'b1}})
                            drop_d = drop_q + {{(DROP_CNT_BITS-1){1'b0}}, 1'b1};
                    end else begin
                        event_d   = assembled;
                        valid_d   = 1'b1;
                        err_ts_d  = !ts_order_ok;
                        last_ts_d = assembled[TIMESTAMP_US_BITS-1:0];
                    end
                end
                default: state_d = WAIT_HI;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_HI;
            hi_q       <= '0;
            event_q    <= '0;
            valid_q    <= 1'b0;
            err_addr_q <= 1'b0;
            err_ts_q   <= 1'b0;
            drop_q     <= '0;
            last_ts_q  <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            event_q    <= event_d;
            valid_q    <= valid_d;
            err_addr_q <= err_addr_d;
            err_ts_q   <= err_ts_d;
            drop_q     <= drop_d;
            last_ts_q  <= last_ts_d;
        end
    end

    assign event_out       = event_q;
    assign event_out_valid = valid_q;
    assign err_addr        = err_addr_q;
    assign err_ts_order    = err_ts_q;
    assign drop_count      = drop_q;

endmodule

// File: tb/tb_ravens_event_depacketizer.sv
// Directed bench for ravens_event_depacketizer.
module tb_ravens_event_depacketizer;

    // Narrow counter so saturation is reachable in a short run
    localparam int DCB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pkt_in = '0;
    logic        pkt_in_valid = 1'b0;
    logic        pkt_in_ready;
    logic        resync = 1'b0;
    logic [63:0] event_out;
    logic        event_out_valid;
    logic        event_out_ready = 1'b1;
    logic        err_addr;
    logic        err_ts_order;
    logic [DCB-1:0] drop_count;

    int n_vec = 0;
    int n_err = 0;

    always #25 clk = ~clk;

    ravens_event_depacketizer #(.DROP_CNT_BITS(DCB)) dut (
        .clk             (clk),
        .rst             (rst),
        .pkt_in          (pkt_in),
        .pkt_in_valid    (pkt_in_valid),
        .pkt_in_ready    (pkt_in_ready),
        .resync          (resync),
        .event_out       (event_out),
        .event_out_valid (event_out_valid),
        .event_out_ready (event_out_ready),
        .err_addr        (err_addr),
        .err_ts_order    (err_ts_order),
        .drop_count      (drop_count)
    );

    function automatic logic [63:0] mk_ev(input logic [8:0] x, input logic [8:0] y,
                                          input logic p, input logic [44:0] ts);
        return {x, y, p, ts};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one word until accepted; ready is sampled mid-cycle
    task automatic send_pkt(input logic [31:0] w);
        logic rdy;
        int   tries;
        pkt_in       = w;
        pkt_in_valid = 1'b1;
        tries        = 0;
        do begin
            @(negedge clk);
            rdy = pkt_in_ready;
            tick();
            tries++;
        end while (!rdy && tries < 60);
        pkt_in_valid = 1'b0;
        if (!rdy) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: word %h never accepted", w);
        end
    endtask

    task automatic send_ev(input logic [63:0] ev);
        send_pkt(ev[63:32]);
        send_pkt(ev[31:0]);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (pkt_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", pkt_in_ready); end
        n_vec++; if (event_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", event_out_valid); end
        n_vec++; if (event_out !== 64'd0) begin n_err++; $display("FAIL rst_event: got %h want 0", event_out); end
        n_vec++; if (drop_count !== '0 || err_addr !== 1'b0 || err_ts_order !== 1'b0) begin
            n_err++; $display("FAIL rst_flags: drop %0d ea %b et %b want 0", drop_count, err_addr, err_ts_order); end
        rst = 1'b0;
        #1;
        n_vec++; if (pkt_in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", pkt_in_ready); end
    endtask

    task automatic test_single;
        logic [63:0] e;
        e = mk_ev(9'd345, 9'd259, 1'b1, 45'h1_2345_6789);
        send_ev(e);
        n_vec++; if (event_out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", event_out_valid); end
        n_vec++; if (event_out !== e) begin n_err++; $display("FAIL single_event: got %h want %h", event_out, e); end
        n_vec++; if (err_addr !== 1'b0 || err_ts_order !== 1'b0) begin
            n_err++; $display("FAIL single_err: ea %b et %b want 0 0", err_addr, err_ts_order); end
        tick();
        n_vec++; if (event_out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", event_out_valid); end
    endtask

    task automatic test_addr_drop;
        send_ev(mk_ev(9'd346, 9'd10, 1'b0, 45'h2_0000_0000));
        n_vec++; if (event_out_valid !== 1'b0) begin n_err++; $display("FAIL drop_x_valid: got %b want 0", event_out_valid); end
        n_vec++; if (err_addr !== 1'b1) begin n_err++; $display("FAIL drop_x_err: got %b want 1", err_addr); end
        n_vec++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL drop_x_cnt: got %0d want 1", drop_count); end
        tick();
        n_vec++; if (err_addr !== 1'b0) begin n_err++; $display("FAIL drop_pulse: got %b want 0", err_addr); end
        send_ev(mk_ev(9'd0, 9'd260, 1'b0, 45'h2_0000_0000));
        n_vec++; if (drop_count !== 8'd2 || err_addr !== 1'b1) begin
            n_err++; $display("FAIL drop_y: cnt %0d ea %b want 2 1", drop_count, err_addr); end
        for (int i = 0; i < 253; i++) send_ev(mk_ev(9'd511, 9'd511, 1'b1, 45'd0));
        n_vec++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL drop_full: got %0d want 255", drop_count); end
        for (int i = 0; i < 5; i++) send_ev(mk_ev(9'd400, 9'd3, 1'b0, 45'd0));
        n_vec++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL drop_sat: got %0d want 255", drop_count); end
        n_vec++; if (event_out_valid !== 1'b0) begin n_err++; $display("FAIL drop_no_event: got %b want 0", event_out_valid); end
    endtask

    task automatic test_ts_order;
        rst = 1'b1; tick(); rst = 1'b0;
        send_ev(mk_ev(9'd5, 9'd6, 1'b0, 45'd1000));
        n_vec++; if (event_out_valid !== 1'b1 || err_ts_order !== 1'b0) begin
            n_err++; $display("FAIL ts_first: v %b et %b want 1 0", event_out_valid, err_ts_order); end
        send_ev(mk_ev(9'd5, 9'd6, 1'b1, 45'd999));
        n_vec++; if (event_out_valid !== 1'b1 || err_ts_order !== 1'b1) begin
            n_err++; $display("FAIL ts_back: v %b et %b want 1 1", event_out_valid, err_ts_order); end
        n_vec++; if (event_out !== mk_ev(9'd5, 9'd6, 1'b1, 45'd999)) begin
            n_err++; $display("FAIL ts_back_ev: got %h", event_out); end
        tick();
        n_vec++; if (err_ts_order !== 1'b0) begin n_err++; $display("FAIL ts_pulse: got %b want 0", err_ts_order); end
        send_ev(mk_ev(9'd7, 9'd8, 1'b0, 45'd999));
        n_vec++; if (event_out_valid !== 1'b1 || err_ts_order !== 1'b0) begin
            n_err++; $display("FAIL ts_equal: v %b et %b want 1 0", event_out_valid, err_ts_order); end
        tick();
    endtask

    task automatic test_backpressure;
        logic [63:0] ev [3];
        logic [63:0] got [$];
        int w;
        ev[0] = mk_ev(9'd10, 9'd20, 1'b1, 45'd2000);
        ev[1] = mk_ev(9'd11, 9'd21, 1'b0, 45'd2001);
        ev[2] = mk_ev(9'd12, 9'd22, 1'b1, 45'd2002);
        event_out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) send_ev(ev[i]);
            end
            begin
                w = 0;
                while (!event_out_valid && w < 20) begin tick(); w++; end
                for (int i = 0; i < 10; i++) begin
                    n_vec++; if (event_out_valid !== 1'b1 || event_out !== ev[0]) begin
                        n_err++; $display("FAIL bp_hold%0d: v %b ev %h want 1 %h", i, event_out_valid, event_out, ev[0]); end
                    tick();
                end
                n_vec++; if (pkt_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", pkt_in_ready); end
                event_out_ready = 1'b1;
                for (int i = 0; i < 40 && got.size() < 3; i++) begin
                    if (event_out_valid) got.push_back(event_out);
                    tick();
                end
            end
        join
        n_vec++; if (got.size() != 3) begin n_err++; $display("FAIL bp_count: got %0d want 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            n_vec++; if (got[i] !== ev[i]) begin n_err++; $display("FAIL bp_order%0d: got %h want %h", i, got[i], ev[i]); end
        end
        tick();
    endtask

    task automatic test_resync;
        logic [63:0] junk, good;
        junk = mk_ev(9'd100, 9'd100, 1'b0, 45'h1_FFFF_FFFF);
        good = mk_ev(9'd33, 9'd44, 1'b1, 45'd3000);
        send_pkt(junk[63:32]);
        resync = 1'b1;
        pkt_in = 32'hDEAD_BEEF; pkt_in_valid = 1'b1;
        #1;
        n_vec++; if (pkt_in_ready !== 1'b0) begin n_err++; $display("FAIL resync_ready: got %b want 0", pkt_in_ready); end
        tick();
        resync = 1'b0; pkt_in_valid = 1'b0;
        send_pkt(good[63:32]);
        n_vec++; if (event_out_valid !== 1'b0) begin n_err++; $display("FAIL resync_early: got %b want 0", event_out_valid); end
        send_pkt(good[31:0]);
        n_vec++; if (event_out_valid !== 1'b1 || event_out !== good) begin
            n_err++; $display("FAIL resync_event: v %b ev %h want 1 %h", event_out_valid, event_out, good); end
        tick();
        n_vec++; if (event_out_valid !== 1'b0) begin n_err++; $display("FAIL resync_extra: got %b want 0", event_out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] ev [4];
        int cyc [$];
        logic [63:0] got [$];
        for (int i = 0; i < 4; i++) ev[i] = mk_ev(9'(i + 1), 9'(i + 2), i[0], 45'(4000 + i));
        event_out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) send_ev(ev[i]);
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    tick();
                    if (event_out_valid) begin cyc.push_back(c); got.push_back(event_out); end
                end
            end
        join
        n_vec++; if (cyc.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", cyc.size()); end
        for (int i = 1; i < cyc.size(); i++) begin
            n_vec++; if (cyc[i] - cyc[i-1] != 2) begin
                n_err++; $display("FAIL b2b_gap%0d: got %0d want 2", i, cyc[i] - cyc[i-1]); end
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            n_vec++; if (got[i] !== ev[i]) begin n_err++; $display("FAIL b2b_ev%0d: got %h want %h", i, got[i], ev[i]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] e;
        e = mk_ev(9'd200, 9'd150, 1'b0, 45'd10);
        send_pkt(32'hFFFF_0000);
        rst = 1'b1;
        tick();
        n_vec++; if (event_out_valid !== 1'b0 || event_out !== 64'd0 || drop_count !== '0) begin
            n_err++; $display("FAIL midrst_out: v %b ev %h drop %0d want 0", event_out_valid, event_out, drop_count); end
        rst = 1'b0;
        send_ev(e);
        n_vec++; if (event_out_valid !== 1'b1 || event_out !== e || err_ts_order !== 1'b0) begin
            n_err++; $display("FAIL midrst_event: v %b ev %h et %b want 1 %h 0", event_out_valid, event_out, err_ts_order, e); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_addr_drop();
        test_ts_order();
        test_backpressure();
        test_resync();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ravens_event_depacketizer.md
Name: ravens_event_depacketizer

Overview:
- Receive end of the DVS-to-RAVENS link: accepts the 32-bit RAVENS packet stream and rebuilds full DVS events (X, Y, polarity, 45-bit microsecond timestamp).
- Two packets per event; each event is range-checked and timestamp-order-checked.
- Used at the neuromorphic-side boundary and as loopback checker for the camera-side packetizer.

Parameters:
- DROP_CNT_BITS, 16, width of saturating dropped-event counter.
- (Field widths come from dvs_ravens_pkg: X/Y address 9 bits each, TIMESTAMP_US_BITS 45, EVENT_BITS 64, RAVENS_PKT_BITS 32.)

Ports:
- clk  in  1  system clock, 50 ns period.
- rst  in  1  synchronous, active-high reset.
- pkt_in  in  RAVENS_PKT_BITS  incoming RAVENS packet.
- pkt_in_valid  in  1  packet present.
- pkt_in_ready  out  1  packet accepted when valid&&ready.
- resync  in  1  discard partial event, realign to high word.
- event_out  out  EVENT_BITS  {x, y, pol, ts}, x in MSBs.
- event_out_valid  out  1  event held.
- event_out_ready  in  1  downstream accepts.
- err_addr  out  1  one-cycle pulse: event dropped for out-of-range address.
- err_ts_order  out  1  one-cycle pulse: emitted event timestamp < previous.
- drop_count  out  DROP_CNT_BITS  saturating count of dropped events.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Packet format:
  - High word (first) = event[63:32] = {x[8:0], y[8:0], pol, ts[44:32]}.
  - Low word (second) = event[31:0] = ts[31:0].
- Assembly FSM:
  - WAIT_HI: on accept, latch the high word, go to WAIT_LO.
  - WAIT_LO: on accept, validate and go to WAIT_HI.
- pkt_in_ready = !resync && (state==WAIT_HI || !event_out_valid || event_out_ready).
- Validation on low-word accept:
  - Drop if x >= 346 or y >= 260: no output, err_addr=1 next cycle, drop_count+1 (saturates at all-ones).
  - Otherwise register the event. event_out_valid rises the cycle after the low-word accept (latency 1 cycle from second packet).
  - If ts < last_ts, err_ts_order=1 in that same cycle. The event is still emitted.
  - last_ts updates to ts for every emitted event. Equal timestamps are legal.
- Output stability: event_out and event_out_valid are held stable until event_out_ready. Valid drops the cycle after handshake unless a new event is registered in that cycle.
- Back-to-back: a low word may be accepted in the same cycle the held event is consumed. Sustained throughput is one event per 2 cycles.
- resync=1:
  - Forces state to WAIT_HI next cycle and discards any latched high word.
  - Does not touch a held output event, last_ts, or drop_count.
  - Packets presented during resync are not accepted.
- Reset values: state WAIT_HI, event_out 0, event_out_valid 0, pkt_in_ready 0 during reset (then 1), err_addr 0, err_ts_order 0, drop_count 0, last_ts 0.
- Reset mid-event discards the partial and any held output.
- Arithmetic:
  - Timestamp compare is unsigned over the full 45 bits; no wrap handling (45-bit µs does not wrap in practice).
  - Address compares are unsigned 9-bit.

Decomposition:
- Add to dvs_ravens_pkg:
  - RAVENS_WORDS_PER_EVENT = 2.
  - Field offset constants (X_MSB, Y_MSB, POL_BIT, TS_HI_BITS = 13).
  - typedef struct packed dvs_event_t {x, y, pol, ts}.
  - Enum ravens_depkt_state_t.
- One natural sub-module: dvs_event_checker. It is combinational and takes event plus last_ts, returning addr_ok and ts_order_ok. It is reusable by the packetizer's input checks.

Test Plan:
- Single event x=345, y=259, pol=1, ts=45'h1_2345_6789, ready=1 -> event_out_valid 1 cycle after second packet, fields exact, no errors.
- x=346, y=10 -> no event_out_valid, err_addr pulse 1 cycle, drop_count=1. Then 65536 bad events -> drop_count stays 65535.
- Events with ts=1000 then ts=999 -> both emitted, err_ts_order pulses with the second. Following ts=999 gives no error.
- event_out_ready held 0 for 10 cycles with three events offered -> first event stable, pkt_in_ready low after the next high word. Release ready -> all three emitted in order, none lost.
- High word sent, resync pulsed, then a full event -> only the full event emitted, with correct fields.
- Continuous valid packets with ready=1 -> one event per 2 cycles. rst asserted between high and low words -> outputs 0, next two packets form a new event.
